// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, so in_ready is registered.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH      = 96,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter bit               CLEAR_DATA = 1'b1
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned      CNT_W      = 16
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_d, out_valid_d;
    logic [1:0]       occupancy_d;
    logic             in_fire, out_fire;

    // State and all outputs come straight from flops; out_data is the main entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            out_data  <= RESET_VAL;
            skid_q    <= RESET_VAL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state_q   <= state_d;
            out_data  <= main_d;
            skid_q    <= skid_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            occupancy <= occupancy_d;
        end
    end

    // Next-state and payload steering; flush overrides every handshake.
    always_comb begin
        state_d  = state_q;
        main_d   = out_data;
        skid_d   = skid_q;
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;

        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_DATA) begin
                main_d = RESET_VAL;
                skid_d = RESET_VAL;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = SKID;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        if (CLEAR_DATA) main_d = RESET_VAL;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = FULL;
                        if (CLEAR_DATA) skid_d = RESET_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        in_ready_d  = (state_d != SKID);
        out_valid_d = (state_d != EMPTY);
        case (state_d)
            FULL:    occupancy_d = 2'd1;
            SKID:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters; a clear takes precedence over an increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!out_valid && out_ready && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (16-bit payload, bubble value 0).
module tb_pipe_stage_reg;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic             cnt_clr;
    logic [3:0]       stall_cnt;
    logic [3:0]       bubble_cnt;
`endif

    int tests_run;
    int tests_failed;

    pipe_stage_reg #(
        .WIDTH      (WIDTH),
        .RESET_VAL  ({WIDTH{1'b0}}),
        .CLEAR_DATA (1'b1)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W      (4)
`endif
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: valid, data, ready, occupancy.
    task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                             input logic r, input logic [1:0] occ);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".out_data"},  32'(out_data),  32'(d));
        check({tag, ".in_ready"},  32'(in_ready),  32'(r));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
        cnt_clr   = 1'b0;
`endif
        #12;
        check_out("reset", 1'b0, 16'h0, 1'b1, 2'd0);
        step();
        reset_n = 1'b1;
        step();
        check_out("idle", 1'b0, 16'h0, 1'b1, 2'd0);

        // Streaming: one item per cycle, one-cycle latency.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 16'(i);
            step();
            check_out($sformatf("stream%0d", i), 1'b1, 16'(i), 1'b1, 2'd1);
        end
        in_valid = 1'b0;
        step();
        check_out("stream_drain", 1'b0, 16'h0, 1'b1, 2'd0);

        // Backpressure: fill both entries, third item held upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        step();
        check_out("bp_a", 1'b1, 16'h000A, 1'b1, 2'd1);
        in_data = 16'h000B;
        step();
        check_out("bp_b", 1'b1, 16'h000A, 1'b0, 2'd2);
        in_data = 16'h000C;
        step();
        check_out("bp_hold", 1'b1, 16'h000A, 1'b0, 2'd2);
        out_ready = 1'b1;
        step();
        check_out("bp_out_b", 1'b1, 16'h000B, 1'b1, 2'd1);
        step();
        check_out("bp_out_c", 1'b1, 16'h000C, 1'b1, 2'd1);
        in_valid = 1'b0;
        step();
        check_out("bp_drain", 1'b0, 16'h0, 1'b1, 2'd0);

        // Asynchronous reset while holding two entries.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0011;
        step();
        in_data = 16'h0022;
        step();
        check_out("pre_rst", 1'b1, 16'h0011, 1'b0, 2'd2);
        reset_n = 1'b0;
        #1;
        check_out("mid_rst", 1'b0, 16'h0, 1'b1, 2'd0);
        in_valid = 1'b0;
        #1;
        reset_n = 1'b1;
        step();
        check_out("post_rst", 1'b0, 16'h0, 1'b1, 2'd0);

        // Flush with skid full and a concurrent upstream push of 0xD.
        in_valid = 1'b1;
        in_data  = 16'h0001;
        step();
        in_data = 16'h0002;
        step();
        check_out("pre_flush", 1'b1, 16'h0001, 1'b0, 2'd2);
        flush    = 1'b1;
        in_data  = 16'h000D;
        step();
        check_out("flush_skid", 1'b0, 16'h0, 1'b1, 2'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_out("flush_no_d", 1'b0, 16'h0, 1'b1, 2'd0);

        // Flush while the main entry is being consumed.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0005;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check_out("flush_fire", 1'b1, 16'h0005, 1'b1, 2'd1);
        step();
        check_out("flush_fire_after", 1'b0, 16'h0, 1'b1, 2'd0);
        flush = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter saturates at 15 and clears on cnt_clr.
        cnt_clr   = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0007;
        step();
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        repeat (20) step();
        check("stall_sat", 32'(stall_cnt), 32'd15);
        check("bubble_idle", 32'(bubble_cnt), 32'd0);
        cnt_clr = 1'b1;
        step();
        check("stall_clr", 32'(stall_cnt), 32'd0);
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("bubble_inc", 32'(bubble_cnt), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
